// File: rtl/xgmii_link_fault_pkg.sv
// Shared types and XGMII constants for the link fault monitor.
package xgmii_link_fault_pkg;

  typedef enum logic [1:0] {
    LINK_OK           = 2'b00,
    LINK_LOCAL_FAULT  = 2'b01,
    LINK_REMOTE_FAULT = 2'b10
  } link_fault_t;

  typedef enum logic [1:0] {
    COL_OTHER,
    COL_LF,
    COL_RF
  } column_kind_t;

  localparam logic [31:0] XGMII_IDLE_WORD = 32'h07070707;
  localparam logic [31:0] XGMII_LF_WORD   = 32'h0100009C;
  localparam logic [31:0] XGMII_RF_WORD   = 32'h0200009C;
  localparam logic [3:0]  XGMII_SEQ_CTRL  = 4'b0001;

  localparam logic [63:0] XGMII_IDLE_BUS  = {XGMII_IDLE_WORD, XGMII_IDLE_WORD};
  localparam logic [7:0]  XGMII_IDLE_CTRL = 8'hFF;
  localparam logic [63:0] XGMII_RF_BUS    = {XGMII_RF_WORD, XGMII_RF_WORD};
  localparam logic [7:0]  XGMII_RF_CTRL   = {XGMII_SEQ_CTRL, XGMII_SEQ_CTRL};

  // Fault status a completed sequence of this column kind declares.
  function automatic link_fault_t kind_to_fault(input column_kind_t kind);
    case (kind)
      COL_LF:  return LINK_LOCAL_FAULT;
      COL_RF:  return LINK_REMOTE_FAULT;
      default: return LINK_OK;
    endcase
  endfunction

endpackage

// File: rtl/xgmii_column_classifier.sv
// Classifies one 32-bit XGMII column as local fault, remote fault or other.
module xgmii_column_classifier
  import xgmii_link_fault_pkg::*;
(
  input  logic [31:0]  word,
  input  logic [3:0]   ctrl,
  output column_kind_t kind
);

  // Only a sequence ordered set in lane 0 with the exact fault code counts.
  always_comb begin
    kind = COL_OTHER;
    if (ctrl == XGMII_SEQ_CTRL) begin
      if (word == XGMII_LF_WORD)      kind = COL_LF;
      else if (word == XGMII_RF_WORD) kind = COL_RF;
    end
  end

endmodule

// File: rtl/xgmii_link_fault_monitor.sv
// RS link fault monitor on the 64-bit XGMII bus: detects LF/RF ordered sets
// on RX, reports link status, and replaces the core's TX stream while faulted.
// Optional fault statistics counters: define XGMII_LINK_FAULT_STATS_EN.
module xgmii_link_fault_monitor
  import xgmii_link_fault_pkg::*;
#(
  parameter int P_FAULT_SEQ_THRESHOLD = 4,
  parameter int P_COL_WINDOW          = 128
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic [63:0] i_xgmii_rx_data,
  input  logic [7:0]  i_xgmii_rx_control,
  output logic [63:0] o_xgmii_rx_data,
  output logic [7:0]  o_xgmii_rx_control,
  input  logic [63:0] i_xgmii_tx_data,
  input  logic [7:0]  i_xgmii_tx_control,
  output logic [63:0] o_xgmii_tx_data,
  output logic [7:0]  o_xgmii_tx_control,
  output logic [1:0]  o_link_fault,
  output logic        o_link_up,
  output logic [15:0] o_local_fault_count,
  output logic [15:0] o_remote_fault_count
);

  localparam int CW = $clog2(P_COL_WINDOW + 1);
  localparam logic [CW-1:0] THRESH = CW'(P_FAULT_SEQ_THRESHOLD);
  localparam logic [CW-1:0] WINDOW = CW'(P_COL_WINDOW);

  column_kind_t  kind [2];
  column_kind_t  seq_type, seq_type_n;
  logic [CW-1:0] seq_cnt, seq_cnt_n;
  logic [CW-1:0] col_cnt, col_cnt_n;
  link_fault_t   link_fault, link_fault_n;
  logic          init_done, init_done_n;

  for (genvar c = 0; c < 2; c++) begin : g_col
    xgmii_column_classifier u_cls (
      .word (i_xgmii_rx_data[32*c +: 32]),
      .ctrl (i_xgmii_rx_control[4*c +: 4]),
      .kind (kind[c])
    );
  end

  // Walk column0 then column1 through the sequence/window state machine.
  always_comb begin
    seq_type_n   = seq_type;
    seq_cnt_n    = seq_cnt;
    col_cnt_n    = col_cnt;
    link_fault_n = link_fault;
    init_done_n  = init_done;
    for (int c = 0; c < 2; c++) begin
      if (kind[c] != COL_OTHER) begin
        if (kind[c] == seq_type_n) begin
          if (seq_cnt_n < THRESH) seq_cnt_n = seq_cnt_n + 1'b1;
        end else begin
          // A different fault type restarts the sequence from one.
          seq_type_n = kind[c];
          seq_cnt_n  = CW'(1);
        end
        col_cnt_n = '0;
        if (seq_cnt_n == THRESH) link_fault_n = kind_to_fault(kind[c]);
      end else begin
        col_cnt_n = col_cnt_n + 1'b1;
        if (col_cnt_n == WINDOW) begin
          seq_type_n   = COL_OTHER;
          seq_cnt_n    = '0;
          col_cnt_n    = '0;
          link_fault_n = LINK_OK;
          init_done_n  = 1'b1;
        end
      end
    end
  end

  // Monitor state plus registered RX/TX datapaths and link status.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      seq_type           <= COL_OTHER;
      seq_cnt            <= '0;
      col_cnt            <= '0;
      link_fault         <= LINK_OK;
      init_done          <= 1'b0;
      o_link_up          <= 1'b0;
      o_xgmii_rx_data    <= XGMII_IDLE_BUS;
      o_xgmii_rx_control <= XGMII_IDLE_CTRL;
      o_xgmii_tx_data    <= XGMII_IDLE_BUS;
      o_xgmii_tx_control <= XGMII_IDLE_CTRL;
    end else begin
      seq_type   <= seq_type_n;
      seq_cnt    <= seq_cnt_n;
      col_cnt    <= col_cnt_n;
      link_fault <= link_fault_n;
      init_done  <= init_done_n;
      o_link_up  <= (link_fault_n == LINK_OK) && init_done_n;
      // Hide fault ordered sets from the core while any fault is pending.
      if (link_fault_n != LINK_OK) begin
        o_xgmii_rx_data    <= XGMII_IDLE_BUS;
        o_xgmii_rx_control <= XGMII_IDLE_CTRL;
      end else begin
        o_xgmii_rx_data    <= i_xgmii_rx_data;
        o_xgmii_rx_control <= i_xgmii_rx_control;
      end
      // TX override switches immediately, truncating any frame in flight.
      case (link_fault)
        LINK_OK: begin
          o_xgmii_tx_data    <= i_xgmii_tx_data;
          o_xgmii_tx_control <= i_xgmii_tx_control;
        end
        LINK_LOCAL_FAULT: begin
          o_xgmii_tx_data    <= XGMII_RF_BUS;
          o_xgmii_tx_control <= XGMII_RF_CTRL;
        end
        default: begin
          o_xgmii_tx_data    <= XGMII_IDLE_BUS;
          o_xgmii_tx_control <= XGMII_IDLE_CTRL;
        end
      endcase
    end
  end

  assign o_link_fault = link_fault;

`ifdef XGMII_LINK_FAULT_STATS_EN
  logic [15:0] lf_count, rf_count;

  // Count entries into each fault state, saturating at all-ones.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      lf_count <= '0;
      rf_count <= '0;
    end else begin
      if (link_fault_n == LINK_LOCAL_FAULT && link_fault != LINK_LOCAL_FAULT &&
          lf_count != 16'hFFFF)
        lf_count <= lf_count + 16'd1;
      if (link_fault_n == LINK_REMOTE_FAULT && link_fault != LINK_REMOTE_FAULT &&
          rf_count != 16'hFFFF)
        rf_count <= rf_count + 16'd1;
    end
  end

  assign o_local_fault_count  = lf_count;
  assign o_remote_fault_count = rf_count;
`else
  assign o_local_fault_count  = 16'h0000;
  assign o_remote_fault_count = 16'h0000;
`endif

endmodule

// File: tb/tb_xgmii_link_fault_monitor.sv
// Directed self-checking bench for xgmii_link_fault_monitor.
module tb_xgmii_link_fault_monitor;

  localparam logic [31:0] IW  = 32'h07070707;
  localparam logic [31:0] LFW = 32'h0100009C;
  localparam logic [31:0] RFW = 32'h0200009C;
  localparam logic [3:0]  SQ  = 4'h1;
  localparam logic [3:0]  IC  = 4'hF;
  localparam logic [63:0] IDLE64 = 64'h0707070707070707;
  localparam logic [63:0] RF64   = 64'h0200009C0200009C;
  localparam logic [63:0] MARK64 = 64'hA5A5_5A5A_C3C3_3C3C;
  localparam logic [63:0] DAT64  = 64'h1122334455667788;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] rx_data_in, tx_data_in, rx_data_out, tx_data_out;
  logic [7:0]  rx_ctrl_in, tx_ctrl_in, rx_ctrl_out, tx_ctrl_out;
  logic [1:0]  link_fault;
  logic        link_up;
  logic [15:0] lf_count, rf_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  xgmii_link_fault_monitor dut (
    .i_clock              (clk),
    .i_reset_n            (rst_n),
    .i_xgmii_rx_data      (rx_data_in),
    .i_xgmii_rx_control   (rx_ctrl_in),
    .o_xgmii_rx_data      (rx_data_out),
    .o_xgmii_rx_control   (rx_ctrl_out),
    .i_xgmii_tx_data      (tx_data_in),
    .i_xgmii_tx_control   (tx_ctrl_in),
    .o_xgmii_tx_data      (tx_data_out),
    .o_xgmii_tx_control   (tx_ctrl_out),
    .o_link_fault         (link_fault),
    .o_link_up            (link_up),
    .o_local_fault_count  (lf_count),
    .o_remote_fault_count (rf_count)
  );

  // One clock with the given RX columns; returns 1 time unit after the edge.
  task automatic cyc(input logic [31:0] w0, input logic [3:0] c0,
                     input logic [31:0] w1, input logic [3:0] c1);
    rx_data_in = {w1, w0};
    rx_ctrl_in = {c1, c0};
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(IW, IC, IW, IC);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tx_data_in = MARK64; tx_ctrl_in = 8'h00;
    cyc(LFW, SQ, LFW, SQ);
    cyc(LFW, SQ, LFW, SQ);
    checks++; if (rx_data_out !== IDLE64) begin errors++; $display("FAIL reset_rx_data got %h exp %h", rx_data_out, IDLE64); end
    checks++; if (rx_ctrl_out !== 8'hFF) begin errors++; $display("FAIL reset_rx_ctrl got %h exp ff", rx_ctrl_out); end
    checks++; if (tx_data_out !== IDLE64) begin errors++; $display("FAIL reset_tx_data got %h exp %h", tx_data_out, IDLE64); end
    checks++; if (tx_ctrl_out !== 8'hFF) begin errors++; $display("FAIL reset_tx_ctrl got %h exp ff", tx_ctrl_out); end
    checks++; if (link_fault !== 2'b00) begin errors++; $display("FAIL reset_link_fault got %b exp 00", link_fault); end
    checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL reset_link_up got %b exp 0", link_up); end
    checks++; if (lf_count !== 16'd0 || rf_count !== 16'd0) begin errors++; $display("FAIL reset_counts got %0d/%0d exp 0/0", lf_count, rf_count); end
    rst_n = 1'b1;
  endtask

  task automatic test_link_up;
    logic [63:0] fd [3];
    logic [7:0]  fc [3];
    fd[0] = 64'hD5555555555555FB; fc[0] = 8'h01;
    fd[1] = 64'h0123456789ABCDEF; fc[1] = 8'h00;
    fd[2] = 64'h070707FD44332211; fc[2] = 8'hF0;
    tx_data_in = IDLE64; tx_ctrl_in = 8'hFF;
    for (int i = 1; i <= 64; i++) begin
      cyc(IW, IC, IW, IC);
      if (i == 63) begin
        checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL up_early got %b exp 0", link_up); end
      end
    end
    checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL up_after_64 got %b exp 1", link_up); end
    checks++; if (link_fault !== 2'b00) begin errors++; $display("FAIL up_fault got %b exp 00", link_fault); end
    for (int k = 0; k < 3; k++) begin
      tx_data_in = fd[k]; tx_ctrl_in = fc[k];
      cyc(IW, IC, IW, IC);
      checks++; if (tx_data_out !== fd[k] || tx_ctrl_out !== fc[k]) begin errors++; $display("FAIL tx_frame%0d got %h/%h exp %h/%h", k, tx_data_out, tx_ctrl_out, fd[k], fc[k]); end
    end
    tx_data_in = MARK64; tx_ctrl_in = 8'h00;
  endtask

  task automatic test_local_fault;
    cyc(LFW, SQ, LFW, SQ);
    checks++; if (link_fault !== 2'b00) begin errors++; $display("FAIL lf_two_seq got %b exp 00", link_fault); end
    cyc(LFW, SQ, LFW, SQ);
    checks++; if (link_fault !== 2'b01) begin errors++; $display("FAIL lf_declared got %b exp 01", link_fault); end
    checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL lf_up got %b exp 0", link_up); end
    checks++; if (rx_data_out !== IDLE64 || rx_ctrl_out !== 8'hFF) begin errors++; $display("FAIL lf_rx_idle got %h/%h exp %h/ff", rx_data_out, rx_ctrl_out, IDLE64); end
    checks++; if (tx_data_out !== MARK64) begin errors++; $display("FAIL lf_tx_prev got %h exp %h", tx_data_out, MARK64); end
  endtask

  task automatic test_fault_hold;
    for (int i = 0; i < 63; i++) begin
      if (i == 0) begin
        rx_data_in = DAT64; rx_ctrl_in = 8'h00;
        @(posedge clk); #1;
        checks++; if (tx_data_out !== RF64 || tx_ctrl_out !== 8'h11) begin errors++; $display("FAIL lf_tx_rf got %h/%h exp %h/11", tx_data_out, tx_ctrl_out, RF64); end
        checks++; if (rx_data_out !== IDLE64 || rx_ctrl_out !== 8'hFF) begin errors++; $display("FAIL lf_rx_suppress got %h/%h exp %h/ff", rx_data_out, rx_ctrl_out, IDLE64); end
      end else cyc(IW, IC, IW, IC);
    end
    checks++; if (link_fault !== 2'b01) begin errors++; $display("FAIL hold_126col got %b exp 01", link_fault); end
    cyc(IW, IC, LFW, SQ);
    checks++; if (link_fault !== 2'b01) begin errors++; $display("FAIL hold_lf_col got %b exp 01", link_fault); end
    idle_cycles(63);
    checks++; if (link_fault !== 2'b01 || link_up !== 1'b0) begin errors++; $display("FAIL hold_63 got %b/%b exp 01/0", link_fault, link_up); end
    idle_cycles(1);
    checks++; if (link_fault !== 2'b00 || link_up !== 1'b1) begin errors++; $display("FAIL clear_64 got %b/%b exp 00/1", link_fault, link_up); end
    rx_data_in = DAT64; rx_ctrl_in = 8'h00;
    @(posedge clk); #1;
    checks++; if (rx_data_out !== DAT64 || rx_ctrl_out !== 8'h00) begin errors++; $display("FAIL rx_pass got %h/%h exp %h/00", rx_data_out, rx_ctrl_out, DAT64); end
    checks++; if (tx_data_out !== MARK64 || tx_ctrl_out !== 8'h00) begin errors++; $display("FAIL tx_pass got %h/%h exp %h/00", tx_data_out, tx_ctrl_out, MARK64); end
  endtask

  task automatic test_remote_alternate;
    for (int i = 0; i < 8; i++) begin
      cyc(RFW, SQ, LFW, SQ);
      checks++; if (link_fault !== 2'b00) begin errors++; $display("FAIL alt%0d got %b exp 00", i, link_fault); end
    end
    checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL alt_up got %b exp 1", link_up); end
    cyc(RFW, SQ, RFW, SQ);
    checks++; if (link_fault !== 2'b00) begin errors++; $display("FAIL rf_two got %b exp 00", link_fault); end
    cyc(RFW, SQ, RFW, SQ);
    checks++; if (link_fault !== 2'b10 || link_up !== 1'b0) begin errors++; $display("FAIL rf_declared got %b/%b exp 10/0", link_fault, link_up); end
    idle_cycles(1);
    checks++; if (tx_data_out !== IDLE64 || tx_ctrl_out !== 8'hFF) begin errors++; $display("FAIL rf_tx_idle got %h/%h exp %h/ff", tx_data_out, tx_ctrl_out, IDLE64); end
    idle_cycles(63);
    checks++; if (link_fault !== 2'b00 || link_up !== 1'b1) begin errors++; $display("FAIL rf_clear got %b/%b exp 00/1", link_fault, link_up); end
  endtask

  task automatic test_mixed_columns;
    cyc(LFW, SQ, LFW, SQ);
    cyc(LFW, SQ, RFW, SQ);
    checks++; if (link_fault !== 2'b00) begin errors++; $display("FAIL mixed_no_lf got %b exp 00", link_fault); end
    cyc(RFW, SQ, RFW, SQ);
    checks++; if (link_fault !== 2'b00) begin errors++; $display("FAIL mixed_rf3 got %b exp 00", link_fault); end
    cyc(RFW, SQ, IW, IC);
    checks++; if (link_fault !== 2'b10) begin errors++; $display("FAIL mixed_rf4 got %b exp 10", link_fault); end
    cyc(LFW, SQ, LFW, SQ);
    checks++; if (link_fault !== 2'b10) begin errors++; $display("FAIL direct_hold got %b exp 10", link_fault); end
    cyc(LFW, SQ, LFW, SQ);
    checks++; if (link_fault !== 2'b01) begin errors++; $display("FAIL direct_rf_to_lf got %b exp 01", link_fault); end
    idle_cycles(64);
    checks++; if (link_fault !== 2'b00 || link_up !== 1'b1) begin errors++; $display("FAIL mixed_clear got %b/%b exp 00/1", link_fault, link_up); end
  endtask

  task automatic test_stats;
    cyc(LFW, SQ, LFW, SQ);
    cyc(LFW, SQ, LFW, SQ);
    idle_cycles(64);
`ifdef XGMII_LINK_FAULT_STATS_EN
    checks++; if (lf_count !== 16'd3) begin errors++; $display("FAIL stats_local got %0d exp 3", lf_count); end
    checks++; if (rf_count !== 16'd2) begin errors++; $display("FAIL stats_remote got %0d exp 2", rf_count); end
`else
    checks++; if (lf_count !== 16'd0) begin errors++; $display("FAIL stats_local_off got %0d exp 0", lf_count); end
    checks++; if (rf_count !== 16'd0) begin errors++; $display("FAIL stats_remote_off got %0d exp 0", rf_count); end
`endif
  endtask

  task automatic test_mid_reset;
    cyc(LFW, SQ, LFW, SQ);
    cyc(LFW, SQ, LFW, SQ);
    checks++; if (link_fault !== 2'b01) begin errors++; $display("FAIL pre_reset_lf got %b exp 01", link_fault); end
    rst_n = 1'b0;
    cyc(LFW, SQ, LFW, SQ);
    checks++; if (link_fault !== 2'b00 || link_up !== 1'b0) begin errors++; $display("FAIL mid_reset_status got %b/%b exp 00/0", link_fault, link_up); end
    checks++; if (rx_data_out !== IDLE64 || tx_data_out !== IDLE64 || tx_ctrl_out !== 8'hFF) begin errors++; $display("FAIL mid_reset_bus got %h/%h/%h", rx_data_out, tx_data_out, tx_ctrl_out); end
    checks++; if (lf_count !== 16'd0 || rf_count !== 16'd0) begin errors++; $display("FAIL mid_reset_counts got %0d/%0d exp 0/0", lf_count, rf_count); end
    rst_n = 1'b1;
    idle_cycles(63);
    checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL reinit_63 got %b exp 0", link_up); end
    idle_cycles(1);
    checks++; if (link_up !== 1'b1 || link_fault !== 2'b00) begin errors++; $display("FAIL reinit_64 got %b/%b exp 1/00", link_up, link_fault); end
  endtask

  initial begin
    rst_n = 1'b0;
    rx_data_in = IDLE64; rx_ctrl_in = 8'hFF;
    tx_data_in = IDLE64; tx_ctrl_in = 8'hFF;
    #2;
    test_reset();
    test_link_up();
    test_local_fault();
    test_fault_hold();
    test_remote_alternate();
    test_mixed_columns();
    test_stats();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
